// File: rtl/two_port_mem_arb_pkg.sv
// Shared types and helpers for the two-port memory arbiter.
// Optional bypass feature elsewhere is enabled by TWO_PORT_MEM_ARB_BYPASS_EN.
package two_port_mem_arb_pkg;

  localparam int N_REQ_DEFAULT = 4;
  localparam int MAX_REQ       = 8;

  typedef logic [N_REQ_DEFAULT-1:0] req_vec_t;

  // Index width for n requesters; never below one bit.
  function automatic int idw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [2:0] onehot2idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/two_port_mem_arb_rr_arbiter.sv
// Round-robin arbiter: search begins at the pointer and wraps; pointer moves
// one past the winner on every grant and holds otherwise.
module rr_arbiter
  import two_port_mem_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDW-1:0]   idx_o,
  output logic             any_o
);

  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   ptr_d;
  logic [N_REQ-1:0] gnt;
  logic [IDW:0]     cand;
  logic             found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    cand  = '0;
    for (int o = 0; o < N_REQ; o++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(o);
      if (cand >= (IDW+1)'(N_REQ)) cand = cand - (IDW+1)'(N_REQ);
      if (!found && req_i[cand[IDW-1:0]]) begin
        gnt[cand[IDW-1:0]] = 1'b1;
        found              = 1'b1;
      end
    end
    // Nothing is granted while reset is held, even with requests pending.
    if (!rst_n) gnt = '0;
  end

  assign gnt_o = gnt;
  assign any_o = |gnt;
  assign idx_o = IDW'(onehot2idx(MAX_REQ'(gnt)));

  always_comb begin
    ptr_d = ptr_q;
    if (any_o) begin
      ptr_d = (idx_o == IDW'(N_REQ - 1)) ? '0 : idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/two_port_mem_arb.sv
// Shares one two-port memory among N_REQ clients with independent round-robin
// arbitration per port. Define TWO_PORT_MEM_ARB_BYPASS_EN for write-first reads.
module two_port_mem_arb
  import two_port_mem_arb_pkg::*;
#(
  parameter  int N_REQ      = 4,
  parameter  int BIT_LENGTH = 64,
  parameter  int DEPTH      = 16,
  localparam int AW         = idw_of(DEPTH),
  localparam int IDW        = idw_of(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        wr_req,
  input  logic [N_REQ*AW-1:0]     wr_addr,
  input  logic [N_REQ*BIT_LENGTH-1:0] wr_data,
  output logic [N_REQ-1:0]        wr_gnt,
  input  logic [N_REQ-1:0]        rd_req,
  input  logic [N_REQ*AW-1:0]     rd_addr,
  output logic [N_REQ-1:0]        rd_gnt,
  output logic                    rd_rvalid,
  output logic [IDW-1:0]          rd_rid,
  output logic [BIT_LENGTH-1:0]   rd_rdata,
  output logic [AW-1:0]           mem_addra,
  output logic [BIT_LENGTH-1:0]   mem_dina,
  output logic                    mem_wea,
  output logic [AW-1:0]           mem_addrb,
  output logic                    mem_enb,
  input  logic [BIT_LENGTH-1:0]   mem_doutb
);

  logic [AW-1:0]         wr_addr_arr [N_REQ];
  logic [BIT_LENGTH-1:0] wr_data_arr [N_REQ];
  logic [AW-1:0]         rd_addr_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign wr_addr_arr[gi] = wr_addr[gi*AW +: AW];
    assign wr_data_arr[gi] = wr_data[gi*BIT_LENGTH +: BIT_LENGTH];
    assign rd_addr_arr[gi] = rd_addr[gi*AW +: AW];
  end

  logic [IDW-1:0] wr_idx;
  logic [IDW-1:0] rd_idx;
  logic           wr_any;
  logic           rd_any;

  rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_wr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (wr_req),
    .gnt_o (wr_gnt),
    .idx_o (wr_idx),
    .any_o (wr_any)
  );

  rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_rd_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (rd_req),
    .gnt_o (rd_gnt),
    .idx_o (rd_idx),
    .any_o (rd_any)
  );

  // Idle ports drive zeros so the memory inputs stay quiet.
  always_comb begin
    mem_wea   = wr_any;
    mem_addra = wr_any ? wr_addr_arr[wr_idx] : '0;
    mem_dina  = wr_any ? wr_data_arr[wr_idx] : '0;
    mem_enb   = rd_any;
    mem_addrb = rd_any ? rd_addr_arr[rd_idx] : '0;
  end

  logic           rvalid_q;
  logic [IDW-1:0] rid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rid_q    <= '0;
    end else begin
      rvalid_q <= rd_any;
      if (rd_any) rid_q <= rd_idx;
    end
  end

  // A read granted just before reset must not surface while reset is held.
  assign rd_rvalid = rvalid_q & rst_n;
  assign rd_rid    = rid_q;

`ifdef TWO_PORT_MEM_ARB_BYPASS_EN
  logic                  byp_q;
  logic [BIT_LENGTH-1:0] byp_data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      byp_q <= wr_any && rd_any && (mem_addra == mem_addrb);
      if (wr_any && rd_any && (mem_addra == mem_addrb)) byp_data_q <= mem_dina;
    end
  end

  assign rd_rdata = byp_q ? byp_data_q : mem_doutb;
`else
  assign rd_rdata = mem_doutb;
`endif

endmodule

// File: tb/tb_two_port_mem_arb.sv
// Directed bench for two_port_mem_arb with an attached read-first memory and a
// cycle-level reference model of arbitration and read return.
module tb_two_port_mem_arb;

  localparam int N   = 4;
  localparam int BL  = 64;
  localparam int DEP = 16;
  localparam int AW  = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    wr_req, rd_req, wr_gnt, rd_gnt;
  logic [N*AW-1:0] wr_addr, rd_addr;
  logic [N*BL-1:0] wr_data;
  logic            rd_rvalid;
  logic [1:0]      rd_rid;
  logic [BL-1:0]   rd_rdata, mem_dina, mem_doutb;
  logic [AW-1:0]   mem_addra, mem_addrb;
  logic            mem_wea, mem_enb;

  logic [AW-1:0] wa [N];
  logic [AW-1:0] ra [N];
  logic [BL-1:0] wd [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  two_port_mem_arb #(.N_REQ(N), .BIT_LENGTH(BL), .DEPTH(DEP)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_rvalid(rd_rvalid), .rd_rid(rd_rid), .rd_rdata(rd_rdata),
    .mem_addra(mem_addra), .mem_dina(mem_dina), .mem_wea(mem_wea),
    .mem_addrb(mem_addrb), .mem_enb(mem_enb), .mem_doutb(mem_doutb)
  );

  always_comb begin
    wr_addr = '0;
    rd_addr = '0;
    wr_data = '0;
    for (int i = 0; i < N; i++) begin
      wr_addr[i*AW +: AW] = wa[i];
      rd_addr[i*AW +: AW] = ra[i];
      wr_data[i*BL +: BL] = wd[i];
    end
  end

  // Attached memory: one-cycle registered read, read-first on collisions.
  logic [BL-1:0] tmem [DEP];
  always @(posedge clk) begin
    if (mem_enb) mem_doutb <= tmem[mem_addrb];
    if (mem_wea) tmem[mem_addra] <= mem_dina;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model.
  logic [BL-1:0] model_mem [DEP];
  int            m_wptr = 0, m_rptr = 0;
  int            cur_w = -1, cur_r = -1;
  logic          m_rv = 1'b0;
  int            m_rid = 0;
  logic [BL-1:0] m_rdata = '0;

  function automatic int pick(input logic [N-1:0] req, input int ptr);
    for (int o = 0; o < N; o++) begin
      if (req[(ptr + o) % N]) return (ptr + o) % N;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    logic [N-1:0] eg;
    cur_w = rst_n ? pick(wr_req, m_wptr) : -1;
    cur_r = rst_n ? pick(rd_req, m_rptr) : -1;
    eg = (cur_w >= 0) ? N'(1 << cur_w) : '0;
    chk("wr_gnt", 64'(wr_gnt), 64'(eg));
    chk("mem_wea", 64'(mem_wea), 64'(cur_w >= 0));
    chk("mem_addra", 64'(mem_addra), (cur_w >= 0) ? 64'(wa[cur_w]) : 64'd0);
    chk("mem_dina", mem_dina, (cur_w >= 0) ? wd[cur_w] : 64'd0);
    eg = (cur_r >= 0) ? N'(1 << cur_r) : '0;
    chk("rd_gnt", 64'(rd_gnt), 64'(eg));
    chk("mem_enb", 64'(mem_enb), 64'(cur_r >= 0));
    chk("mem_addrb", 64'(mem_addrb), (cur_r >= 0) ? 64'(ra[cur_r]) : 64'd0);
    chk("rd_rvalid", 64'(rd_rvalid), 64'(m_rv && rst_n));
    if (m_rv && rst_n) begin
      chk("rd_rid", 64'(rd_rid), 64'(m_rid));
      chk("rd_rdata", rd_rdata, m_rdata);
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_wptr <= 0;
      m_rptr <= 0;
      m_rv   <= 1'b0;
    end else begin
      m_rv <= (cur_r >= 0);
      if (cur_r >= 0) begin
        m_rid  <= cur_r;
        m_rptr <= (cur_r + 1) % N;
        m_rdata <= model_mem[ra[cur_r]];
`ifdef TWO_PORT_MEM_ARB_BYPASS_EN
        if (cur_w >= 0 && wa[cur_w] == ra[cur_r]) m_rdata <= wd[cur_w];
`endif
      end
      if (cur_w >= 0) begin
        model_mem[wa[cur_w]] <= wd[cur_w];
        m_wptr <= (cur_w + 1) % N;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] seq [4];
  logic [BL-1:0] coll_exp;

  initial begin
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000;
`ifdef TWO_PORT_MEM_ARB_BYPASS_EN
    coll_exp = 64'h1;
`else
    coll_exp = 64'hAAAA_AAAA_AAAA_AAAA;
`endif
    for (int i = 0; i < DEP; i++) begin
      tmem[i] = '0;
      model_mem[i] = '0;
    end
    mem_doutb = '0;
    for (int i = 0; i < N; i++) begin
      wa[i] = AW'(i + 8);
      ra[i] = AW'(i);
      wd[i] = 64'h100 + 64'(i);
    end
    rst_n = 1'b0;
    wr_req = 4'b1111;
    rd_req = 4'b1111;

    tick(); #3;
    $display("txn: reset with all requests pending");
    chk("reset wr_gnt", 64'(wr_gnt), 64'd0);
    chk("reset rd_gnt", 64'(rd_gnt), 64'd0);
    chk("reset rd_rvalid", 64'(rd_rvalid), 64'd0);
    tick(); tick();
    rst_n = 1'b1; wr_req = '0; rd_req = '0;

    for (int c = 0; c < 8; c++) begin
      tick();
      wr_req = 4'b1111;
      for (int i = 0; i < N; i++) wd[i] = 64'h1000 * 64'(c) + 64'(i);
      #3;
      $display("txn: round-robin write cycle %0d", c);
      chk("rr wr_gnt", 64'(wr_gnt), 64'(seq[c % 4]));
      chk("rr mem_wea", 64'(mem_wea), 64'd1);
    end

    tick(); wa[0] = 3; wd[0] = 64'hAAAA_AAAA_AAAA_AAAA; wr_req = 4'b0001; #3;
    $display("txn: client 0 writes addr 3");
    chk("init wr_gnt", 64'(wr_gnt), 64'b0001);

    tick(); wa[2] = 5; wd[2] = 64'hDEAD_BEEF; wr_req = 4'b0100; #3;
    $display("txn: client 2 writes addr 5");
    chk("c2 wr_gnt", 64'(wr_gnt), 64'b0100);

    tick(); wr_req = '0; ra[1] = 5; rd_req = 4'b0010; #3;
    $display("txn: client 1 reads addr 5");
    chk("c1 rd_gnt", 64'(rd_gnt), 64'b0010);
    chk("c1 mem_addrb", 64'(mem_addrb), 64'd5);

    tick(); rd_req = '0; #3;
    chk("c1 rvalid", 64'(rd_rvalid), 64'd1);
    chk("c1 rid", 64'(rd_rid), 64'd1);
    chk("c1 rdata", rd_rdata, 64'hDEAD_BEEF);

    tick(); wa[0] = 3; wd[0] = 64'h1; wr_req = 4'b0001; ra[3] = 3; rd_req = 4'b1000; #3;
    $display("txn: same-cycle write and read of addr 3");
    chk("coll wr_gnt", 64'(wr_gnt), 64'b0001);
    chk("coll rd_gnt", 64'(rd_gnt), 64'b1000);

    tick(); wr_req = '0; rd_req = '0; #3;
    chk("coll rid", 64'(rd_rid), 64'd3);
    chk("coll rdata", rd_rdata, coll_exp);

    tick(); rd_req = 4'b1000; #3;
    $display("txn: lone request from client 3");
    chk("wrap rd_gnt a", 64'(rd_gnt), 64'b1000);

    tick(); ra[0] = 5; rd_req = 4'b1001; #3;
    $display("txn: clients 0 and 3 after pointer wrap");
    chk("wrap rd_gnt b", 64'(rd_gnt), 64'b0001);
    chk("wrap rdata", rd_rdata, 64'h1);

    tick(); ra[2] = 5; rd_req = 4'b0100; #3;
    $display("txn: client 2 read then reset");
    chk("pre-rst rd_gnt", 64'(rd_gnt), 64'b0100);

    tick(); rst_n = 1'b0; rd_req = '0; #3;
    chk("rst drop rvalid", 64'(rd_rvalid), 64'd0);
    tick(); #3;
    chk("rst hold rvalid", 64'(rd_rvalid), 64'd0);

    tick(); rst_n = 1'b1; rd_req = 4'b1111; wr_req = 4'b1111; #3;
    $display("txn: all clients request after reset");
    chk("post-rst rd_gnt", 64'(rd_gnt), 64'b0001);
    chk("post-rst wr_gnt", 64'(wr_gnt), 64'b0001);

    tick(); rd_req = '0; wr_req = '0; #3;
    chk("post-rst rdata", rd_rdata, 64'hDEAD_BEEF);

    for (int c = 0; c < 5; c++) begin
      tick(); #3;
      $display("txn: idle cycle %0d", c);
      chk("idle mem_wea", 64'(mem_wea), 64'd0);
      chk("idle mem_enb", 64'(mem_enb), 64'd0);
      chk("idle rvalid", 64'(rd_rvalid), 64'd0);
    end

    tick(); rd_req = 4'b1111; wr_req = 4'b1111; #3;
    $display("txn: all clients request after idle");
    chk("idle ptr rd_gnt", 64'(rd_gnt), 64'b0010);
    chk("idle ptr wr_gnt", 64'(wr_gnt), 64'b0010);

    tick(); rd_req = '0; wr_req = '0;
    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/two_port_mem_arb.md
Name: two_port_mem_arb

Overview:
- Shares one `two_port_mem` instance between N_REQ clients.
- Write port A and read port B each get an independent round-robin arbiter.
- Sits between the NN compute lanes and the shared feature/weight buffer. It drives the memory's addra/dina/wea/addrb/enb and consumes doutb.
- Read responses return with the winning requester's ID, aligned to the memory's 1-cycle registered read.

Parameters:
- N_REQ, 4, number of requesters per port (2..8).
- BIT_LENGTH, 64, data width; must match the memory.
- DEPTH, 16, memory depth; AW = $clog2(DEPTH).
- IDW, derived, $clog2(N_REQ); not user-overridable.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- wr_req  in  N_REQ  per-client write request, held until granted
- wr_addr  in  N_REQ*AW  packed write addresses, client i at [i*AW +: AW]
- wr_data  in  N_REQ*BIT_LENGTH  packed write data
- wr_gnt  out  N_REQ  one-hot write grant; write commits this cycle
- rd_req  in  N_REQ  per-client read request, held until granted
- rd_addr  in  N_REQ*AW  packed read addresses
- rd_gnt  out  N_REQ  one-hot read grant
- rd_rvalid  out  1  read data valid
- rd_rid  out  IDW  requester index of the returned data
- rd_rdata  out  BIT_LENGTH  read data
- mem_addra  out  AW  to memory addra
- mem_dina  out  BIT_LENGTH  to memory dina
- mem_wea  out  1  to memory wea
- mem_addrb  out  AW  to memory addrb
- mem_enb  out  1  to memory enb
- mem_doutb  in  BIT_LENGTH  from memory doutb

Behaviour:
- Single clock clk. Reset is synchronous, active-low (rst_n), sampled on posedge clk.
- Grants are combinational from req and the registered priority pointer; at most one bit of each grant is set.
- wr_gnt[i] means: mem_wea=1, mem_addra=wr_addr[i], mem_dina=wr_data[i] in the same cycle. The client drops or advances its req on the next cycle.
- rd_gnt[i] means: mem_enb=1, mem_addrb=rd_addr[i] in the same cycle.
- With no request on a port, its mem_we*/mem_en* is 0 and its addr/data are driven 0.
- Round-robin arbitration, per port: pointer ptr (IDW bits).
  - Search starts at ptr and wraps modulo N_REQ.
  - On any grant to client k, ptr <= (k+1) mod N_REQ. With no grant, ptr holds.
  - Continuous requesters are starved for at most N_REQ-1 cycles.
- Read return:
  - rd_rvalid and rd_rid are registered from (|rd_gnt, encoded index).
  - rd_rdata = mem_doutb combinationally, so data appears exactly 1 cycle after the grant.
  - Back-to-back grants give back-to-back rvalid.
- Reset values: ptr_wr=0, ptr_rd=0, rd_rvalid=0, rd_rid=0. Grants are 0 while rst_n=0, even if requests are present.
- Reset mid-operation: an in-flight read (granted the cycle before reset is asserted) is dropped, so rd_rvalid=0 during reset. The memory contents are untouched.
- Same-cycle write and read to the same address:
  - Without the feature, the read returns the OLD data; this is memory read-first behaviour.
- Out-of-range address (>= DEPTH when DEPTH is not a power of 2): passed through unchecked. Avoiding it is the client's responsibility.

Optional Feature:
- Macro: TWO_PORT_MEM_ARB_BYPASS_EN.
- Defined:
  - When both ports grant in the same cycle with mem_addra == mem_addrb, register a byp flag and mem_dina.
  - Next cycle, rd_rdata = registered data instead of mem_doutb. This gives write-first semantics.
  - byp resets to 0.
- Undefined: no bypass registers; rd_rdata = mem_doutb always.

Decomposition:
- Package two_port_mem_arb_pkg holds:
  - the localparam helper for IDW;
  - a function onehot2idx;
  - typedef req_vec_t (logic [N_REQ-1:0]) where parameterisation allows.
- Sub-module rr_arbiter (req, gnt, idx, ptr register), instantiated twice: once for the write port, once for the read port.

Test Plan:
- N_REQ=4: after reset, wr_req=4'b1111 held for 8 cycles -> wr_gnt sequence 0001,0010,0100,1000,0001,... and mem_wea=1 every cycle.
- Client 2 writes addr 5 = 64'hDEAD_BEEF, then client 1 reads addr 5 -> rd_gnt=4'b0010; next cycle rd_rvalid=1, rd_rid=1, rd_rdata=64'hDEAD_BEEF.
- Same-cycle write of addr 3 = 64'h1 (old value 64'hAAAA_AAAA_AAAA_AAAA) and read of addr 3:
  - without the macro -> rd_rdata=64'hAAAA_AAAA_AAAA_AAAA;
  - with TWO_PORT_MEM_ARB_BYPASS_EN -> 64'h1.
- rd_req=4'b1000 only, then 4'b1001 the next cycle -> grant 1000, then 0001 (pointer wrapped to 0).
- Assert rst_n=0 the cycle after a read grant -> rd_rvalid stays 0, ptr returns to 0, and the next read request from client 0 wins first.
- Idle (all req=0) for 5 cycles -> mem_wea=mem_enb=0, rd_rvalid=0, pointers unchanged.
